// File: rtl/battousai_load_unit.sv
// battousai_load_unit: sequential load unit for the memory stage.
// Accepts a load, issues an aligned bus read, waits for the data, then
// extracts and sign/zero-extends the addressed bytes. Illegal funct3 and
// bus-word-crossing accesses return a fault without touching memory.
// Optional macro BATTOUSAI_LOAD_SPLIT_EN: crossing accesses are served by
// two consecutive bus reads instead of faulting.
module battousai_load_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_instr,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_fault
);

    localparam int         BYTES   = XLEN / 8;
    localparam int         OFF_W   = $clog2(BYTES);
    localparam logic [6:0] OP_LOAD = 7'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
`ifdef BATTOUSAI_LOAD_SPLIT_EN
        , S_REQ2
        , S_WAIT2
`endif
    } state_t;

    state_t state;

    // Request decode, evaluated on the live request bus
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              illegal_d;
    logic              sgn_d;
    logic              raw_d;
    logic [3:0]        size_d;
    logic [OFF_W-1:0]  off_d;
    logic              cross_d;
    logic              fault_d;
    logic [ADDR_W-1:0] aligned_d;

    // Fields of the accepted request
    logic [OFF_W-1:0]  off_p0;
    logic [3:0]        size_p0;
    logic              sgn_p0;
    logic              raw_p0;
`ifdef BATTOUSAI_LOAD_SPLIT_EN
    logic              cross_p0;
    logic [XLEN-1:0]   word0_p0;
`endif

    // Instruction bits outside opcode/funct3 carry no meaning here
    logic unused_instr;
    assign unused_instr = ^{req_instr[31:15], req_instr[11:7]};

    // Shift the (possibly two-word) read data down to the addressed byte,
    // keep size bytes and fill the upper bits with the sign or zeros.
    // Passthrough returns the first bus word untouched.
    function automatic logic [XLEN-1:0] extract(
        input logic [2*XLEN-1:0] pair,
        input logic [OFF_W-1:0]  off,
        input logic [3:0]        size,
        input logic              sgn,
        input logic              raw
    );
        logic [2*XLEN-1:0] shifted;
        logic [XLEN-1:0]   mask;
        logic              fill;
        shifted = pair >> {off, 3'b000};
        case (size)
            4'd1: begin mask = XLEN'(8'hFF);          fill = shifted[7];  end
            4'd2: begin mask = XLEN'(16'hFFFF);       fill = shifted[15]; end
            4'd4: begin mask = XLEN'(32'hFFFF_FFFF);  fill = shifted[31]; end
            default: begin mask = '1;                 fill = 1'b0;        end
        endcase
        fill = fill & sgn;
        if (raw)
            return pair[XLEN-1:0];
        return (shifted[XLEN-1:0] & mask) | ({XLEN{fill}} & ~mask);
    endfunction

    // Decode size/sign/legality and detect bus-word crossing
    always_comb begin
        opcode    = req_instr[6:0];
        funct3    = req_instr[14:12];
        raw_d     = (opcode != OP_LOAD);
        illegal_d = 1'b0;
        sgn_d     = 1'b0;
        size_d    = 4'd0;
        if (!raw_d) begin
            case (funct3)
                3'd0: begin size_d = 4'd1; sgn_d = 1'b1; end
                3'd1: begin size_d = 4'd2; sgn_d = 1'b1; end
                3'd2: begin size_d = 4'd4; sgn_d = 1'b1; end
                3'd3: begin
                    if (XLEN == 64) begin
                        size_d = 4'd8;
                        sgn_d  = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                3'd4: size_d = 4'd1;
                3'd5: size_d = 4'd2;
                3'd6: size_d = 4'd4;
                default: illegal_d = 1'b1;
            endcase
        end
        off_d     = req_addr[OFF_W-1:0];
        cross_d   = !raw_d && !illegal_d && ((int'(off_d) + int'(size_d)) > BYTES);
        aligned_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef BATTOUSAI_LOAD_SPLIT_EN
        fault_d   = illegal_d;
`else
        fault_d   = illegal_d || cross_d;
`endif
    end

    // Control FSM with registered handshake, bus and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_fault <= 1'b0;
            off_p0    <= '0;
            size_p0   <= '0;
            sgn_p0    <= 1'b0;
            raw_p0    <= 1'b0;
`ifdef BATTOUSAI_LOAD_SPLIT_EN
            cross_p0  <= 1'b0;
            word0_p0  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        off_p0    <= off_d;
                        size_p0   <= size_d;
                        sgn_p0    <= sgn_d;
                        raw_p0    <= raw_d;
`ifdef BATTOUSAI_LOAD_SPLIT_EN
                        cross_p0  <= cross_d;
`endif
                        if (fault_d) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_data  <= '0;
                            state     <= S_RESP;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= aligned_d;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    mem_rd_en <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rd_valid) begin
`ifdef BATTOUSAI_LOAD_SPLIT_EN
                        if (cross_p0) begin
                            word0_p0  <= mem_rd_data;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= mem_addr + ADDR_W'(BYTES);
                            state     <= S_REQ2;
                        end else begin
                            rsp_data  <= extract({{XLEN{1'b0}}, mem_rd_data}, off_p0, size_p0, sgn_p0, raw_p0);
                            rsp_fault <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
`else
                        rsp_data  <= extract({{XLEN{1'b0}}, mem_rd_data}, off_p0, size_p0, sgn_p0, raw_p0);
                        rsp_fault <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
`endif
                    end
                end
`ifdef BATTOUSAI_LOAD_SPLIT_EN
                S_REQ2: begin
                    mem_rd_en <= 1'b0;
                    state     <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (mem_rd_valid) begin
                        rsp_data  <= extract({mem_rd_data, word0_p0}, off_p0, size_p0, sgn_p0, raw_p0);
                        rsp_fault <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    mem_rd_en <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battousai_load_unit.sv
// tb_battousai_load_unit: scoreboard bench for battousai_load_unit (XLEN=64).
// Build with BATTOUSAI_LOAD_SPLIT_EN defined to exercise the two-read path.
module tb_battousai_load_unit;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;

    localparam logic [31:0] I_LB  = 32'h0000_0003;
    localparam logic [31:0] I_LH  = 32'h0000_1003;
    localparam logic [31:0] I_LW  = 32'h0000_2003;
    localparam logic [31:0] I_LD  = 32'h0000_3003;
    localparam logic [31:0] I_LBU = 32'h0000_4003;
    localparam logic [31:0] I_LHU = 32'h0000_5003;
    localparam logic [31:0] I_LWU = 32'h0000_6003;
    localparam logic [31:0] I_BAD = 32'h0000_7003;
    localparam logic [31:0] I_ADD = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_instr = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_rd_data;
    logic              mem_rd_valid;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_fault;

    typedef struct {
        logic [63:0] data;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mem [logic [63:0]];
    logic [63:0] addr_log[$];
    int          mem_delay = 1;
    int          rd_count = 0;
    int          passed = 0;
    int          total = 0;

    battousai_load_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_addr(req_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    // Memory model: answers each read strobe after mem_delay cycles
    initial begin
        logic [63:0] a;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        @(negedge clk);
        forever begin
            if (mem_rd_en === 1'b1) begin
                rd_count++;
                a = mem_addr;
                addr_log.push_back(a);
                repeat (mem_delay) @(negedge clk);
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem.exists(a) ? mem[a] : 64'h0;
                @(negedge clk);
                mem_rd_valid = 1'b0;
                mem_rd_data  = '0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] instr, input logic [63:0] addr,
                         input logic [63:0] edata, input logic efault);
        exp_t e;
        e.data  = edata;
        e.fault = efault;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1;
        req_instr = instr;
        req_addr  = addr;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid, holds rsp_ready low for hold cycles,
    // then completes the handshake. lat = -1 means no response arrived.
    task automatic wait_rsp(input int hold, output logic [63:0] data, output logic fault,
                            output int lat, output logic stable, output logic idle_after);
        lat = 0; data = '0; fault = 1'b0; stable = 1'b1; idle_after = 1'b0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) break;
            if (req_ready !== 1'b0) stable = 1'b0;
        end
        if (rsp_valid !== 1'b1) begin
            lat = -1;
            return;
        end
        data  = rsp_data;
        fault = rsp_fault;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_fault !== fault || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        idle_after = (rsp_valid === 1'b0 && req_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", req_ready); else passed++;
        total++; if (mem_rd_en !== 1'b0) $display("FAIL rst_mem_rd_en: got %b expected 0", mem_rd_en); else passed++;
        total++; if (mem_addr !== 64'h0) $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        total++; if (rsp_data !== 64'h0 || rsp_fault !== 1'b0)
            $display("FAIL rst_rsp: got data %h fault %b expected 0/0", rsp_data, rsp_fault); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic [63:0] d;
        logic        f, st, id;
        int          lat, rc;
        exp_t        e;
        logic [31:0] instrs[8] = '{I_LB, I_LBU, I_LW, I_LWU, I_LD, I_ADD, I_LHU, I_LH};
        logic [63:0] addrs[8]  = '{64'h1003, 64'h1003, 64'h2004, 64'h2004, 64'h2000, 64'h2005, 64'h1001, 64'h1002};
        logic [63:0] exps[8]   = '{64'hFFFF_FFFF_FFFF_FF85, 64'h0000_0000_0000_0085,
                                   64'hFFFF_FFFF_8000_0001, 64'h0000_0000_8000_0001,
                                   64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000,
                                   64'h0000_0000_0000_6677, 64'hFFFF_FFFF_FFFF_8566};
        logic [63:0] bases[8]  = '{64'h1000, 64'h1000, 64'h2000, 64'h2000, 64'h2000, 64'h2000, 64'h1000, 64'h1000};
        mem[64'h1000] = 64'h1122_3344_8566_7788;
        mem[64'h2000] = 64'h8000_0001_0000_0000;
        mem_delay = 1;
        for (int k = 0; k < 8; k++) begin
            rc = rd_count;
            addr_log.delete();
            issue(instrs[k], addrs[k], exps[k], 1'b0);
            wait_rsp(0, d, f, lat, st, id);
            e = exp_q.pop_front();
            total++; if (d !== e.data) $display("FAIL load%0d_data: got %h expected %h", k, d, e.data); else passed++;
            total++; if (f !== e.fault) $display("FAIL load%0d_fault: got %b expected %b", k, f, e.fault); else passed++;
            total++; if (lat !== 3) $display("FAIL load%0d_latency: got %0d expected 3", k, lat); else passed++;
            total++; if (rd_count - rc !== 1) $display("FAIL load%0d_reads: got %0d expected 1", k, rd_count - rc); else passed++;
            total++; if ((addr_log.size() > 0 ? addr_log[0] : 64'hDEAD) !== bases[k])
                $display("FAIL load%0d_mem_addr: got %h expected %h", k,
                         (addr_log.size() > 0 ? addr_log[0] : 64'hDEAD), bases[k]); else passed++;
            total++; if (id !== 1'b1) $display("FAIL load%0d_idle: got %b expected 1", k, id); else passed++;
        end
    endtask

    task automatic test_illegal();
        logic [63:0] d;
        logic        f, st, id;
        int          lat, rc;
        exp_t        e;
        rc = rd_count;
        issue(I_BAD, 64'h2004, 64'h0, 1'b1);
        wait_rsp(0, d, f, lat, st, id);
        e = exp_q.pop_front();
        total++; if (d !== e.data) $display("FAIL illegal_data: got %h expected %h", d, e.data); else passed++;
        total++; if (f !== e.fault) $display("FAIL illegal_fault: got %b expected %b", f, e.fault); else passed++;
        total++; if (lat !== 1) $display("FAIL illegal_latency: got %0d expected 1", lat); else passed++;
        total++; if (rd_count - rc !== 0) $display("FAIL illegal_reads: got %0d expected 0", rd_count - rc); else passed++;
    endtask

    task automatic test_cross();
        logic [63:0] d;
        logic        f, st, id;
        int          lat, rc;
        exp_t        e;
        rc = rd_count;
        addr_log.delete();
`ifdef BATTOUSAI_LOAD_SPLIT_EN
        mem[64'h0000] = 64'hAABB_0000_0000_0000;
        mem[64'h0008] = 64'h0000_0000_0000_CCDD;
        issue(I_LW, 64'h0006, 64'hFFFF_FFFF_CCDD_AABB, 1'b0);
        wait_rsp(0, d, f, lat, st, id);
        e = exp_q.pop_front();
        total++; if (d !== e.data) $display("FAIL split_data: got %h expected %h", d, e.data); else passed++;
        total++; if (f !== e.fault) $display("FAIL split_fault: got %b expected %b", f, e.fault); else passed++;
        total++; if (lat !== 5) $display("FAIL split_latency: got %0d expected 5", lat); else passed++;
        total++; if (rd_count - rc !== 2) $display("FAIL split_reads: got %0d expected 2", rd_count - rc); else passed++;
        total++; if (addr_log.size() != 2 || addr_log[0] !== 64'h0 || addr_log[1] !== 64'h8)
            $display("FAIL split_addrs: got %0d reads, expected reads at 0 then 8", addr_log.size()); else passed++;
`else
        issue(I_LH, 64'h0007, 64'h0, 1'b1);
        wait_rsp(0, d, f, lat, st, id);
        e = exp_q.pop_front();
        total++; if (d !== e.data) $display("FAIL cross_data: got %h expected %h", d, e.data); else passed++;
        total++; if (f !== e.fault) $display("FAIL cross_fault: got %b expected %b", f, e.fault); else passed++;
        total++; if (lat !== 1) $display("FAIL cross_latency: got %0d expected 1", lat); else passed++;
        total++; if (rd_count - rc !== 0) $display("FAIL cross_reads: got %0d expected 0", rd_count - rc); else passed++;
`endif
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        logic        f, st, id;
        int          lat, rc;
        exp_t        e;
        mem_delay = 4;
        rc = rd_count;
        issue(I_LB, 64'h1003, 64'hFFFF_FFFF_FFFF_FF85, 1'b0);
        wait_rsp(5, d, f, lat, st, id);
        e = exp_q.pop_front();
        total++; if (d !== e.data) $display("FAIL bp_data: got %h expected %h", d, e.data); else passed++;
        total++; if (lat !== 6) $display("FAIL bp_latency: got %0d expected 6", lat); else passed++;
        total++; if (rd_count - rc !== 1) $display("FAIL bp_reads: got %0d expected 1", rd_count - rc); else passed++;
        total++; if (st !== 1'b1) $display("FAIL bp_stable: got %b expected 1", st); else passed++;
        total++; if (id !== 1'b1) $display("FAIL bp_idle: got %b expected 1", id); else passed++;
        mem_delay = 1;
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic        f, st, id, seen;
        int          lat, rc;
        exp_t        e;
        mem_delay = 6;
        rc = rd_count;
        issue(I_LWU, 64'h2004, 64'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL midrst_ctrl: got ready %b rd_en %b valid %b expected 1/0/0", req_ready, mem_rd_en, rsp_valid); else passed++;
        total++; if (mem_addr !== 64'h0 || rsp_data !== 64'h0 || rsp_fault !== 1'b0)
            $display("FAIL midrst_data: got addr %h data %h fault %b expected 0/0/0", mem_addr, rsp_data, rsp_fault); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd_en !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL midrst_stale: got activity %b expected 0", seen); else passed++;
        total++; if (rd_count - rc !== 1) $display("FAIL midrst_reads: got %0d expected 1", rd_count - rc); else passed++;
        mem_delay = 1;
        issue(I_LBU, 64'h1003, 64'h0000_0000_0000_0085, 1'b0);
        wait_rsp(0, d, f, lat, st, id);
        e = exp_q.pop_front();
        total++; if (d !== e.data || f !== e.fault)
            $display("FAIL midrst_next: got %h/%b expected %h/%b", d, f, e.data, e.fault); else passed++;
        total++; if (lat !== 3) $display("FAIL midrst_next_latency: got %0d expected 3", lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_illegal();
        test_cross();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
